// File: rtl/multdiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers: 34 cycles per mult/div.
// Define MULTDIV_SIGNED_EN to build signed mult/div; otherwise every op runs unsigned.
module multdiv_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] srca_i,
    input  logic [31:0] srcb_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] opb_q, opb_d;
    logic        div_q, div_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] mag_a, mag_b;
    logic [63:0] prod;
    logic [31:0] quo, remv;

`ifdef MULTDIV_SIGNED_EN
    logic sa, sb;
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    assign sa    = ~op_i[0] & srca_i[31];
    assign sb    = ~op_i[0] & srcb_i[31];
    // 0x80000000 negates to itself and is then read as an unsigned magnitude.
    assign mag_a = sa ? -srca_i : srca_i;
    assign mag_b = sb ? -srcb_i : srcb_i;
    assign prod  = negq_q ? -acc_q : acc_q;
    assign quo   = negq_q ? -acc_q[31:0] : acc_q[31:0];
    assign remv  = negr_q ? -rem_q : rem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end
`else
    assign mag_a = srca_i;
    assign mag_b = srcb_i;
    assign prod  = acc_q;
    assign quo   = acc_q[31:0];
    assign remv  = rem_q;
`endif

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

    // Restoring divide: quotient bits shift into acc[31:0] as dividend bits shift out.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_take;
    assign div_shift = {rem_q, acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    assign div_take  = ~div_diff[33];

    logic unused_bits;
    assign unused_bits = div_diff[32] ^ op_i[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opb_d   = opb_q;
        div_d   = div_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULTDIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = op_i[1] ? S_DIV : S_MUL;
                    cnt_d   = 5'd0;
                    acc_d   = {32'd0, mag_a};
                    rem_d   = 32'd0;
                    opb_d   = mag_b;
                    div_d   = op_i[1];
                    dz_d    = (srcb_i == 32'd0);
`ifdef MULTDIV_SIGNED_EN
                    negq_d  = sa ^ sb;
                    negr_d  = sa;
`endif
                end else begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIN;
            end
            S_DIV: begin
                rem_d = div_take ? div_diff[31:0] : div_shift[31:0];
                acc_d = {acc_q[63:32], acc_q[30:0], div_take};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIN;
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // Divide by zero leaves rem = |a|, which the sign fix turns back into srca.
                    lo_d = dz_q ? 32'hFFFF_FFFF : quo;
                    hi_d = remv;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            opb_q   <= 32'd0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit; expectations follow MULTDIV_SIGNED_EN.
module tb_multdiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] srca_i = 32'd0;
    logic [31:0] srcb_i = 32'd0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int errs = 0;
    int checks = 0;

    multdiv_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .srca_i(srca_i), .srcb_i(srcb_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    // Called #1 after a rising edge; returns #1 after the edge that raises done (or after the bound).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok, output bit hold_ok);
        logic [31:0] h0, l0;
        h0 = hi_o; l0 = lo_o;
        op_i = op; srca_i = a; srcb_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        op_i = ~op; srca_i = ~a; srcb_i = ~b;
        busy_ok = (busy_o === 1'b1); hold_ok = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (hi_o !== h0 || lo_o !== l0) hold_ok = 1'b0;
            @(posedge clk_i); #1;
            if (done_o === 1'b1) begin lat = i; break; end
            if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if (hi_o !== 32'd0) begin errs++; $display("FAIL reset_hi got=%h want=0", hi_o); end
        checks++; if (lo_o !== 32'd0) begin errs++; $display("FAIL reset_lo got=%h want=0", lo_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_mtlo_mthi;
        mtlo_i = 1'b1; wdata_i = 32'h1234;
        @(posedge clk_i); #1; mtlo_i = 1'b0;
        checks++; if (lo_o !== 32'h1234) begin errs++; $display("FAIL mtlo got=%h want=00001234", lo_o); end
        checks++; if (hi_o !== 32'd0) begin errs++; $display("FAIL mtlo_hi got=%h want=0", hi_o); end
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hA5A5_5A5A;
        @(posedge clk_i); #1; mthi_i = 1'b0; mtlo_i = 1'b0;
        checks++; if (hi_o !== 32'hA5A5_5A5A || lo_o !== 32'hA5A5_5A5A) begin
            errs++; $display("FAIL mt_both got=%h/%h want=a5a55a5a/a5a55a5a", hi_o, lo_o); end
    endtask

    task automatic test_multu;
        int lat; bit bok, hok;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat, bok, hok);
        checks++; if (lat !== 33) begin errs++; $display("FAIL multu_lat got=%0d want=33", lat); end
        checks++; if (!bok) begin errs++; $display("FAIL multu_busy got=drop want=held"); end
        checks++; if (!hok) begin errs++; $display("FAIL multu_hold got=changed want=held"); end
        checks++; if (hi_o !== 32'd1 || lo_o !== 32'hFFFF_FFFE) begin
            errs++; $display("FAIL multu_res got=%h/%h want=00000001/fffffffe", hi_o, lo_o); end
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL multu_busy_end got=%b want=0", busy_o); end
        @(posedge clk_i); #1;
        checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL done_width got=%b want=0", done_o); end
    endtask

    task automatic test_divu;
        int lat; bit bok, hok;
        run_op(2'b11, 32'd100, 32'd7, lat, bok, hok);
        checks++; if (lat !== 33) begin errs++; $display("FAIL divu_lat got=%0d want=33", lat); end
        checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin
            errs++; $display("FAIL divu_res got=lo %h hi %h want=lo e hi 2", lo_o, hi_o); end
    endtask

    task automatic test_signed;
        int lat; bit bok, hok;
        logic [31:0] ehi, elo;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bok, hok);
`ifdef MULTDIV_SIGNED_EN
        elo = 32'hFFFF_FFFD; ehi = 32'hFFFF_FFFF;
`else
        elo = 32'h7FFF_FFFC; ehi = 32'd1;
`endif
        checks++; if (lo_o !== elo || hi_o !== ehi) begin
            errs++; $display("FAIL div_sgn got=lo %h hi %h want=lo %h hi %h", lo_o, hi_o, elo, ehi); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bok, hok);
`ifdef MULTDIV_SIGNED_EN
        ehi = 32'hFFFF_FFFF;
`else
        ehi = 32'd1;
`endif
        checks++; if (hi_o !== ehi || lo_o !== 32'hFFFF_FFFE) begin
            errs++; $display("FAIL mult_sgn got=%h/%h want=%h/fffffffe", hi_o, lo_o, ehi); end
    endtask

    task automatic test_div_zero;
        int lat; bit bok, hok;
        run_op(2'b10, 32'd5, 32'd0, lat, bok, hok);
        checks++; if (lat !== 33) begin errs++; $display("FAIL dz_lat got=%0d want=33", lat); end
        checks++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'd5) begin
            errs++; $display("FAIL div_dz got=lo %h hi %h want=lo ffffffff hi 5", lo_o, hi_o); end
        run_op(2'b11, 32'd5, 32'd0, lat, bok, hok);
        checks++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'd5) begin
            errs++; $display("FAIL divu_dz got=lo %h hi %h want=lo ffffffff hi 5", lo_o, hi_o); end
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, bok, hok);
        checks++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'hFFFF_FFFB) begin
            errs++; $display("FAIL div_dz_neg got=lo %h hi %h want=lo ffffffff hi fffffffb", lo_o, hi_o); end
    endtask

    task automatic test_overflow;
        int lat; bit bok, hok;
        logic [31:0] ehi, elo;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, hok);
`ifdef MULTDIV_SIGNED_EN
        elo = 32'h8000_0000; ehi = 32'd0;
`else
        elo = 32'd0; ehi = 32'h8000_0000;
`endif
        checks++; if (lo_o !== elo || hi_o !== ehi) begin
            errs++; $display("FAIL div_ovf got=lo %h hi %h want=lo %h hi %h", lo_o, hi_o, elo, ehi); end
    endtask

    task automatic test_start_mtlo;
        int lat; bit bok, hok;
        mtlo_i = 1'b1; wdata_i = 32'h1234;
        run_op(2'b01, 32'd6, 32'd7, lat, bok, hok);
        checks++; if (!hok) begin errs++; $display("FAIL start_mtlo_hold got=changed want=held"); end
        checks++; if (lo_o !== 32'd42 || hi_o !== 32'd0) begin
            errs++; $display("FAIL start_mtlo got=lo %h hi %h want=lo 2a hi 0", lo_o, hi_o); end
    endtask

    task automatic test_mthi_busy;
        int lat;
        mthi_i = 1'b1; wdata_i = 32'h55;
        @(posedge clk_i); #1; mthi_i = 1'b0;
        checks++; if (hi_o !== 32'h55) begin errs++; $display("FAIL mthi_idle got=%h want=55", hi_o); end
        op_i = 2'b01; srca_i = 32'd3; srcb_i = 32'd4; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        mthi_i = 1'b1; wdata_i = 32'hDEAD;
        repeat (20) @(posedge clk_i);
        #1;
        checks++; if (hi_o !== 32'h55) begin errs++; $display("FAIL mthi_busy got=%h want=55", hi_o); end
        mthi_i = 1'b0;
        lat = -1;
        for (int i = 21; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat !== 33 || hi_o !== 32'd0 || lo_o !== 32'd12) begin
            errs++; $display("FAIL mthi_busy_res got=lat %0d hi %h lo %h want=lat 33 hi 0 lo c", lat, hi_o, lo_o); end
    endtask

    task automatic test_start_busy;
        int lat;
        op_i = 2'b01; srca_i = 32'd3; srcb_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        op_i = 2'b11; srca_i = 32'd100; srcb_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        lat = -1;
        for (int i = 7; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat !== 33 || lo_o !== 32'd15 || hi_o !== 32'd0) begin
            errs++; $display("FAIL start_busy got=lat %0d lo %h hi %h want=lat 33 lo f hi 0", lat, lo_o, hi_o); end
        @(posedge clk_i); #1;
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL start_busy_idle got=%b want=0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok, hok;
        run_op(2'b11, 32'd100, 32'd7, lat, bok, hok);
        run_op(2'b01, 32'd6, 32'd7, lat, bok, hok);
        checks++; if (lat !== 33 || !bok) begin errs++; $display("FAIL b2b_lat got=%0d busy %b want=33 busy 1", lat, bok); end
        checks++; if (lo_o !== 32'd42 || hi_o !== 32'd0) begin
            errs++; $display("FAIL b2b_res got=lo %h hi %h want=lo 2a hi 0", lo_o, hi_o); end
    endtask

    task automatic test_mid_reset;
        int lat, dcount; bit bok, hok;
        op_i = 2'b01; srca_i = 32'hFFFF_FFFF; srcb_i = 32'd2; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1; rst_ni = 1'b0; #1;
        checks++; if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errs++; $display("FAIL mid_reset got=busy %b hi %h lo %h want=0 0 0", busy_o, hi_o, lo_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dcount++;
        end
        checks++; if (dcount !== 0) begin errs++; $display("FAIL mid_reset_done got=%0d want=0", dcount); end
        run_op(2'b11, 32'd9, 32'd3, lat, bok, hok);
        checks++; if (lat !== 33 || lo_o !== 32'd3 || hi_o !== 32'd0) begin
            errs++; $display("FAIL post_reset_divu got=lat %0d lo %h hi %h want=lat 33 lo 3 hi 0", lat, lo_o, hi_o); end
    endtask

    initial begin
        test_reset();
        test_mtlo_mthi();
        test_multu();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_mtlo();
        test_mthi_busy();
        test_start_busy();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS core. It executes mult/multu/div/divu as a 34-cycle multi-cycle operation alongside the single-cycle datapath. It exposes `busy` so the core's control can stall mfhi/mflo and further mult/div instructions until the result is ready. It owns the HI/LO architectural state, including mthi/mtlo writes.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, active-low.
- `start`  in  1  request a new operation. Sampled only in IDLE.
- `op`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- `srca`  in  32  multiplicand or dividend (rs).
- `srcb`  in  32  multiplier or divisor (rt).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  data for mthi/mtlo.
- `busy`  out  1  operation in flight (MUL, DIV or FIN).
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE. `start` with op[1]=0 goes to MUL; `start` with op[1]=1 goes to DIV.
  - MUL or DIV. Runs for 32 iterations, counted by a 5-bit counter, then goes to FIN.
  - FIN. Writes the result and returns to IDLE.
- Signedness:
  - Signed ops (op[0]=0) latch |srca| and |srcb| and record the result sign flags at start.
  - |0x80000000| = 0x80000000, treated as unsigned.
- MUL: shift-add, one multiplier bit per cycle, into a 64-bit accumulator. In FIN the product is negated (two's complement, 64 bit) if sign(a) XOR sign(b). hi = product[63:32], lo = product[31:0].
- DIV: restoring division, one quotient bit per cycle, with a 33-bit partial remainder. In FIN:
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder is negated if sign(a).
  - lo = quotient, hi = remainder.
- Divide by zero: takes the full 34 cycles. Result is lo = 0xFFFFFFFF, hi = srca as latched, regardless of signedness.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No flag is raised.
- mthi/mtlo:
  - In IDLE, written at the clock edge. Both may be asserted together.
  - While `busy`=1, ignored. The core must stall these instructions.
- `start` while busy is ignored.
- `start` together with mthi/mtlo in IDLE: start wins and the writes are dropped.
- srca, srcb and op are latched at start. Later input changes do not affect the operation in flight.
- HI/LO keep their old values throughout MUL and DIV and change only at the FIN edge.

## Timing
- Reset (asynchronous, `reset`=0):
  - State = IDLE.
  - busy = 0, done = 0, hi = 0, lo = 0.
  - Counter and accumulators are cleared.
  - Any operation in flight is aborted with no HI/LO update.
- Cycle numbering: edge E0 samples `start`.
  - busy = 1 from E0.
  - Iterations occur at edges E1..E32.
  - HI/LO are written at E33; busy = 0 and done = 1 during the cycle after E33.
- done is high for exactly one cycle.
- A new `start` may be sampled at E34, i.e. the cycle in which done = 1. Back-to-back throughput is one operation per 34 cycles.
- `busy` is registered (a state decode only), with no combinational path from inputs.
- Reset deasserted mid-cycle: the block leaves reset at the next rising edge in IDLE.

## Configuration
- `MULTDIV_SIGNED_EN` defined:
  - mult/div perform signed operations as described above.
- `MULTDIV_SIGNED_EN` undefined:
  - op[0] is ignored and all operations are unsigned: mult behaves as multu, div as divu.
  - Sign and negation logic is not synthesized.
  - Timing is unchanged.

## Test plan
- multu 0xFFFFFFFF × 2:
  - hi = 0x00000001, lo = 0xFFFFFFFE at E33.
  - busy high E0..E33, done pulses once.
- divu 100 / 7:
  - lo = 14, hi = 2.
- div 0xFFFFFFF9 / 2:
  - With `MULTDIV_SIGNED_EN`: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - Without it: lo = 0x7FFFFFFC, hi = 1.
  - mult 0xFFFFFFFF × 2 with the macro: hi = lo-pattern 0xFFFFFFFF/0xFFFFFFFE.
- div/divu 5 / 0:
  - lo = 0xFFFFFFFF, hi = 5 after 34 cycles.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mtlo 0x1234 in IDLE: lo = 0x1234 next cycle.
  - mthi during busy: hi unchanged.
  - start + mtlo same cycle: lo equals the operation result, not wdata.
  - Second start during busy: ignored.
- Reset asserted at E10 of a mult:
  - Immediately busy = 0, hi = lo = 0, done never pulses.
  - A subsequent divu 9 / 3 gives lo = 3, hi = 0.
